uart_tx_frame: RTL

Parametrised UART transmitter that serialises one word per valid/ready handshake. Data width, parity mode, stop-bit count and baud divisor are all configurable. It supersedes the fixed 8N1 edge-triggered transmitter: a bit counter restarts at each frame instead of running free, so every bit lasts exactly one baud period. It sits between a byte/word source (FIFO, command engine) and the board TX pin.

---
 rtl/uart_tx_frame.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: one word per valid/ready handshake, framed as
// start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
module uart_tx_frame #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int BAUD_DIV  = CLK_FREQ / BAUD_RATE,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [15:0] BAUD_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic        HAS_PARITY = 1'(PARITY != 0);

    // Odd parity makes the total count of ones odd, even parity makes it even.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
        if (PARITY == 1) begin
            return ~^word;
        end else begin
            return ^word;
        end
    endfunction

    state_t                 state_r;
    logic [15:0]            baud_cnt_r;
    logic [3:0]             bit_cnt_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   parity_r;
    logic                   tx_out_r;
    logic                   tx_ready_r;
    logic                   tx_done_r;
    logic                   bit_end_s;

    assign bit_end_s = (baud_cnt_r == BAUD_LAST);

    // Frame sequencer: the line level is computed together with the next
    // state so tx_out changes on the same edge the state does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            baud_cnt_r <= 16'd0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= '0;
            parity_r   <= 1'b0;
            tx_out_r   <= 1'b1;
            tx_ready_r <= 1'b1;
            tx_done_r  <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            if (state_r != S_IDLE) begin
                baud_cnt_r <= bit_end_s ? 16'd0 : baud_cnt_r + 16'd1;
            end else begin
                baud_cnt_r <= 16'd0;
            end
            case (state_r)
                S_IDLE: begin
                    tx_out_r <= 1'b1;
                    if (tx_valid && tx_ready_r) begin
                        shift_r    <= tx_data;
                        parity_r   <= parity_bit(tx_data);
                        bit_cnt_r  <= 4'd0;
                        state_r    <= S_START;
                        tx_out_r   <= 1'b0;
                        tx_ready_r <= 1'b0;
                    end else begin
                        tx_ready_r <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end_s) begin
                        state_r  <= S_DATA;
                        tx_out_r <= shift_r[0];
                        shift_r  <= shift_r >> 1;
                    end else begin
                        tx_out_r <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (bit_end_s) begin
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_r <= 4'd0;
                            if (HAS_PARITY) begin
                                state_r  <= S_PARITY;
                                tx_out_r <= parity_r;
                            end else begin
                                state_r  <= S_STOP;
                                tx_out_r <= 1'b1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            tx_out_r  <= shift_r[0];
                            shift_r   <= shift_r >> 1;
                        end
                    end else begin
                        tx_out_r <= tx_out_r;
                    end
                end
                S_PARITY: begin
                    if (bit_end_s) begin
                        state_r  <= S_STOP;
                        tx_out_r <= 1'b1;
                    end else begin
                        tx_out_r <= parity_r;
                    end
                end
                S_STOP: begin
                    tx_out_r <= 1'b1;
                    if (bit_end_s) begin
                        if (bit_cnt_r == STOP_LAST) begin
                            bit_cnt_r  <= 4'd0;
                            state_r    <= S_IDLE;
                            tx_ready_r <= 1'b1;
                            tx_done_r  <= 1'b1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    bit_cnt_r  <= 4'd0;
                    tx_out_r   <= 1'b1;
                    tx_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign tx_out   = tx_out_r;
    assign tx_ready = tx_ready_r;
    assign tx_busy  = ~tx_ready_r;
    assign tx_done  = tx_done_r;

endmodule
